// File: rtl/z88_ps2_kbd.sv
// z88_ps2_kbd: PS/2 set-2 keyboard receiver that maintains the 64-bit Z88 key
// matrix read by Blink on IN $B2. Everything runs on mck. Reset (rin) is
// synchronous and active-high.
// Optional build macro: PS2_PARITY_CHK_EN. When it is defined, the receiver checks
// odd parity over the data and parity bits and drops bytes that fail the check.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit (and parity), then back to IDLE
module z88_ps2_kbd #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 20000
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        byte_vld,
  output logic [7:0]  byte_dat,
  output logic        frm_err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FILT_RLD = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_RLD   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          par_ok;
  logic          frame_ok, frame_bad;
  logic          ext, brk;
  logic [2:0]    skip;
  logic          map_hit;
  logic [5:0]    map_idx;

  // Two-flop synchronisers; both lines idle high, so they are seeded high.
  always_ff @(posedge mck) begin
    if (rin) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the accepted clock level moves only after FILT_LEN equal samples.
  always_ff @(posedge mck) begin
    if (rin) begin
      filt_clk <= 1'b1;
      filt_cnt <= FILT_RLD;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= FILT_RLD;
    end else if (filt_cnt == '0) begin
      filt_clk <= clk_s2;
      filt_cnt <= FILT_RLD;
    end else begin
      filt_cnt <= filt_cnt - FW'(1);
    end
  end

  // One-cycle fall event: the cycle in which the filtered clock is about to drop.
  assign fall = filt_clk & ~clk_s2 & (filt_cnt == '0);

  // Mid-frame watchdog: reloads on every fall and while idle, fires at terminal count.
  always_ff @(posedge mck) begin
    if (rin || state_q == IDLE || fall) begin
      to_cnt <= TO_RLD;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - TW'(1);
    end
  end

  assign to_hit = (state_q != IDLE) && (to_cnt == '0);

`ifdef PS2_PARITY_CHK_EN
  assign par_ok = ^{shreg, par_bit};
`else
  logic unused_par;
  assign unused_par = par_bit;
  assign par_ok     = 1'b1;
`endif

  // Receiver state register.
  always_ff @(posedge mck) begin
    if (rin) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and frame verdict; a watchdog expiry takes priority over a fall.
  always_comb begin
    state_d   = state_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (to_hit) begin
      state_d   = IDLE;
      frame_bad = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE:   if (!dat_s2) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (dat_s2 && par_ok) frame_ok  = 1'b1;
          else                  frame_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame datapath: bit counter, shift register and parity capture.
  always_ff @(posedge mck) begin
    if (rin) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else if (fall && !to_hit) begin
      case (state_q)
        IDLE:    bit_cnt <= 3'd0;
        DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY:  par_bit <= dat_s2;
        default: ;
      endcase
    end
  end

  // Registered byte and error outputs.
  always_ff @(posedge mck) begin
    if (rin) begin
      byte_vld <= 1'b0;
      byte_dat <= 8'h00;
      frm_err  <= 1'b0;
    end else begin
      byte_vld <= frame_ok;
      frm_err  <= frame_bad;
      if (frame_ok) byte_dat <= shreg;
    end
  end

  // Scancode to matrix index, idx = 8*row + bit. Extended codes carry ext in bit 8.
  always_comb begin
    map_hit = 1'b1;
    map_idx = 6'd0;
    case ({ext, byte_dat})
      9'h05A:  map_idx = 6'd6;   // Enter
      9'h059:  map_idx = 6'd7;   // Right shift
      9'h172:  map_idx = 6'd22;  // Cursor down
      9'h175:  map_idx = 6'd30;  // Cursor up
      9'h01B:  map_idx = 6'd36;  // S
      9'h16B:  map_idx = 6'd38;  // Cursor left
      9'h01C:  map_idx = 6'd44;  // A
      9'h174:  map_idx = 6'd46;  // Cursor right
      9'h015:  map_idx = 6'd52;  // Q
      9'h029:  map_idx = 6'd53;  // Space
      9'h00D:  map_idx = 6'd60;  // Tab
      9'h076:  map_idx = 6'd61;  // Esc
      9'h012:  map_idx = 6'd62;  // Left shift
      9'h066:  map_idx = 6'd63;  // Delete / backspace
      default: map_hit = 1'b0;
    endcase
  end

  // Set-2 decoder: prefix tracking, Pause skipping, make/break and matrix clears.
  always_ff @(posedge mck) begin
    if (rin) begin
      kbmat <= 64'd0;
      ext   <= 1'b0;
      brk   <= 1'b0;
      skip  <= 3'd0;
    end else if (byte_vld) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (byte_dat == 8'hE0) begin
        ext <= 1'b1;
      end else if (byte_dat == 8'hF0) begin
        brk <= 1'b1;
      end else if (byte_dat == 8'hE1) begin
        skip <= 3'd7;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext && !brk &&
            (byte_dat == 8'hAA || byte_dat == 8'hFA || byte_dat == 8'hFE)) begin
          kbmat <= 64'd0;
        end else if (map_hit) begin
          kbmat[map_idx] <= ~brk;
        end
      end
    end
  end

endmodule
